slow_stg_rd_sched: RTL and testbench

Read scheduler for the slow (BRAM-backed) merge-tree stages. It sits directly upstream of the slow-stage BRAM read-enable decoder. It collects refill requests from the leaf-level FIFOs of one segment and picks one leaf per read. It then drives decode_en_blk and addr_seg, which enable every BRAM along the root-to-leaf path, and tracks the BRAM read latency so the path returns data before the next issue.

---
 rtl/slow_stg_rd_sched.sv | 159 +++++++++++++++
 tb/tb_slow_stg_rd_sched.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/slow_stg_rd_sched.sv
// Read scheduler for the BRAM-backed merge-tree stages: arbitrates leaf refill requests and paces path reads.
// Optional macro SLOW_STG_RD_SCHED_RR_EN selects round-robin arbitration; fixed lowest-index priority otherwise.
module slow_stg_rd_sched #(
    parameter  int ADDR_W   = 4,
    parameter  int RD_LAT   = 2,
    localparam int NUM_LEAF = 2 ** ADDR_W
) (
    input  logic                clk,
    input  logic                rst_b,
    input  logic [NUM_LEAF-1:0] leaf_req,
    input  logic                stall_in,
    output logic                decode_en_blk,
    output logic [ADDR_W-1:0]   addr_seg,
    output logic [NUM_LEAF-1:0] req_ack,
    output logic                rd_vld,
    output logic [ADDR_W-1:0]   rd_addr,
    output logic                busy
);

    localparam int CNT_W = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    state_t              state_reg;
    logic [CNT_W-1:0]    cnt_reg;
    logic [NUM_LEAF-1:0] pending_reg;
    logic [NUM_LEAF-1:0] pending_next;
    logic [NUM_LEAF-1:0] req_vec;
    logic [ADDR_W-1:0]   addr_seg_reg;
    logic [ADDR_W-1:0]   rd_addr_reg;
    logic                decode_en_reg;
    logic                rd_vld_reg;
    logic                busy_reg;
    logic                can_grant;
    logic                grant_en;
    logic [ADDR_W-1:0]   gnt_idx;
    logic                found;

    assign req_vec   = pending_reg | leaf_req;
    assign can_grant = (state_reg == IDLE) || ((state_reg == WAIT) && (cnt_reg == '0));
    assign grant_en  = can_grant && (|req_vec) && !stall_in;

`ifdef SLOW_STG_RD_SCHED_RR_EN
    logic [ADDR_W-1:0] ptr_reg;

    // Search begins at the pointer; ADDR_W-bit addition wraps NUM_LEAF-1 back to 0.
    always_comb begin
        gnt_idx = '0;
        found   = 1'b0;
        for (int i = 0; i < NUM_LEAF; i++) begin
            if (!found && req_vec[ADDR_W'(ptr_reg + ADDR_W'(i))]) begin
                gnt_idx = ADDR_W'(ptr_reg + ADDR_W'(i));
                found   = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            ptr_reg <= '0;
        end else if (grant_en) begin
            ptr_reg <= gnt_idx + ADDR_W'(1);
        end
    end
`else
    always_comb begin
        gnt_idx = '0;
        found   = 1'b0;
        for (int i = NUM_LEAF - 1; i >= 0; i--) begin
            if (req_vec[i]) begin
                gnt_idx = ADDR_W'(i);
                found   = 1'b1;
            end
        end
    end
`endif

    // A pulse that is itself granted is consumed; only a repeat pulse on an
    // already-pending bit survives that bit's grant.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_LEAF; gi++) begin : g_leaf
            assign req_ack[gi]      = grant_en && found && (gnt_idx == ADDR_W'(gi));
            assign pending_next[gi] = req_ack[gi] ? (pending_reg[gi] & leaf_req[gi])
                                                  : (pending_reg[gi] | leaf_req[gi]);
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_reg     <= IDLE;
            cnt_reg       <= '0;
            pending_reg   <= '0;
            addr_seg_reg  <= '0;
            rd_addr_reg   <= '0;
            decode_en_reg <= 1'b0;
            rd_vld_reg    <= 1'b0;
            busy_reg      <= 1'b0;
        end else begin
            pending_reg   <= pending_next;
            decode_en_reg <= 1'b0;
            rd_vld_reg    <= 1'b0;
            case (state_reg)
                IDLE: begin
                    busy_reg <= grant_en;
                    if (grant_en) begin
                        state_reg     <= ISSUE;
                        decode_en_reg <= 1'b1;
                        addr_seg_reg  <= gnt_idx;
                    end
                end
                ISSUE: begin
                    state_reg <= WAIT;
                    busy_reg  <= 1'b1;
                    cnt_reg   <= CNT_W'(RD_LAT - 1);
                    if (RD_LAT == 1) begin
                        rd_vld_reg  <= 1'b1;
                        rd_addr_reg <= addr_seg_reg;
                    end
                end
                WAIT: begin
                    if (cnt_reg != '0) begin
                        cnt_reg  <= cnt_reg - CNT_W'(1);
                        busy_reg <= 1'b1;
                        // rd_vld is raised one edge early so it is high in the counter-0 cycle.
                        if (cnt_reg == CNT_W'(1)) begin
                            rd_vld_reg  <= 1'b1;
                            rd_addr_reg <= addr_seg_reg;
                        end
                    end else begin
                        busy_reg <= grant_en;
                        if (grant_en) begin
                            state_reg     <= ISSUE;
                            decode_en_reg <= 1'b1;
                            addr_seg_reg  <= gnt_idx;
                        end else begin
                            state_reg <= IDLE;
                        end
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign decode_en_blk = decode_en_reg;
    assign addr_seg      = addr_seg_reg;
    assign rd_vld        = rd_vld_reg;
    assign rd_addr       = rd_addr_reg;
    assign busy          = busy_reg;

endmodule

// File: tb/tb_slow_stg_rd_sched.sv
// Directed bench for slow_stg_rd_sched (RD_LAT=2, 16 leaves); expectations adapt to SLOW_STG_RD_SCHED_RR_EN.
module tb_slow_stg_rd_sched;

    localparam int ADDR_W = 4;
    localparam int RD_LAT = 2;
    localparam int NL     = 16;

    logic          clk = 1'b0;
    logic          rst_b = 1'b1;
    logic [NL-1:0] leaf_req = '0;
    logic          stall_in = 1'b0;
    logic          decode_en_blk;
    logic [ADDR_W-1:0] addr_seg;
    logic [NL-1:0] req_ack;
    logic          rd_vld;
    logic [ADDR_W-1:0] rd_addr;
    logic          busy;

    int n_cmp = 0;
    int n_err = 0;

    slow_stg_rd_sched #(.ADDR_W(ADDR_W), .RD_LAT(RD_LAT)) dut (
        .clk          (clk),
        .rst_b        (rst_b),
        .leaf_req     (leaf_req),
        .stall_in     (stall_in),
        .decode_en_blk(decode_en_blk),
        .addr_seg     (addr_seg),
        .req_ack      (req_ack),
        .rd_vld       (rd_vld),
        .rd_addr      (rd_addr),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are checked 4 units after it.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        #3;
    endtask

    task automatic do_reset();
        rst_b    = 1'b0;
        leaf_req = '0;
        stall_in = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_b = 1'b1;
    endtask

    initial begin
        int first_leaf;
        int second_leaf;
        logic [NL-1:0] oh;
`ifdef SLOW_STG_RD_SCHED_RR_EN
        first_leaf  = 7;
        second_leaf = 1;
`else
        first_leaf  = 1;
        second_leaf = 7;
`endif

        // Reset state
        #2 rst_b = 1'b0;
        #2;
        chk("rst decode_en", 32'(decode_en_blk), 32'd0);
        chk("rst addr_seg",  32'(addr_seg),      32'd0);
        chk("rst req_ack",   32'(req_ack),       32'd0);
        chk("rst rd_vld",    32'(rd_vld),        32'd0);
        chk("rst rd_addr",   32'(rd_addr),       32'd0);
        chk("rst busy",      32'(busy),          32'd0);

        // Single request to leaf 9
        do_reset();
        leaf_req = 16'h0200; mid();
        chk("single ack c0", 32'(req_ack), 32'h0200);
        chk("single busy c0", 32'(busy), 32'd0);
        cyc(); leaf_req = '0; mid();
        chk("single dec c1", 32'(decode_en_blk), 32'd1);
        chk("single addr c1", 32'(addr_seg), 32'd9);
        chk("single busy c1", 32'(busy), 32'd1);
        cyc(); mid();
        chk("single dec c2", 32'(decode_en_blk), 32'd0);
        chk("single vld c2", 32'(rd_vld), 32'd0);
        cyc(); mid();
        chk("single vld c3", 32'(rd_vld), 32'd1);
        chk("single rd_addr c3", 32'(rd_addr), 32'd9);
        $display("single: read leaf %0d returned", rd_addr);
        cyc(); mid();
        chk("single vld c4", 32'(rd_vld), 32'd0);
        chk("single busy c4", 32'(busy), 32'd0);

        // Burst of all 16 leaves
        do_reset();
        leaf_req = 16'hFFFF; mid();
        chk("burst ack c0", 32'(req_ack), 32'h0001);
        for (int c = 1; c <= 49; c++) begin
            bit exp_dec;
            bit exp_vld;
            cyc(); leaf_req = '0; mid();
            exp_dec = ((c - 1) % 3 == 0) && ((c - 1) / 3 < 16);
            exp_vld = (c >= 3) && ((c - 3) % 3 == 0) && ((c - 3) / 3 < 16);
            chk($sformatf("burst dec c%0d", c), 32'(decode_en_blk), 32'(exp_dec));
            chk($sformatf("burst vld c%0d", c), 32'(rd_vld), 32'(exp_vld));
            if (exp_dec) begin
                chk($sformatf("burst addr c%0d", c), 32'(addr_seg), 32'((c - 1) / 3));
                $display("burst: issue c%0d addr_seg=%0d", c, addr_seg);
            end
            if (exp_vld) begin
                chk($sformatf("burst rd_addr c%0d", c), 32'(rd_addr), 32'((c - 3) / 3));
            end
        end
        chk("burst busy end", 32'(busy), 32'd0);

        // Arbitration order after leaf 3 is granted
        do_reset();
        leaf_req = 16'h0008; mid();
        chk("arb ack c0", 32'(req_ack), 32'h0008);
        cyc(); leaf_req = 16'h0082; mid();
        chk("arb dec c1", 32'(decode_en_blk), 32'd1);
        chk("arb addr c1", 32'(addr_seg), 32'd3);
        cyc(); leaf_req = '0;
        cyc(); mid();
        oh = '0; oh[first_leaf] = 1'b1;
        chk("arb ack c3", 32'(req_ack), 32'(oh));
        cyc(); mid();
        chk("arb dec c4", 32'(decode_en_blk), 32'd1);
        chk("arb addr c4", 32'(addr_seg), 32'(first_leaf));
        $display("arb: first issue addr_seg=%0d", addr_seg);
        cyc(); cyc(); mid();
        oh = '0; oh[second_leaf] = 1'b1;
        chk("arb ack c6", 32'(req_ack), 32'(oh));
        cyc(); mid();
        chk("arb dec c7", 32'(decode_en_blk), 32'd1);
        chk("arb addr c7", 32'(addr_seg), 32'(second_leaf));
        $display("arb: second issue addr_seg=%0d", addr_seg);

        // Stall with leaf 2 pending while leaf 9 is in flight
        do_reset();
        leaf_req = 16'h0200; mid();
        cyc(); leaf_req = 16'h0004; stall_in = 1'b1; mid();
        chk("stall dec c1", 32'(decode_en_blk), 32'd1);
        chk("stall addr c1", 32'(addr_seg), 32'd9);
        cyc(); leaf_req = '0; mid();
        chk("stall dec c2", 32'(decode_en_blk), 32'd0);
        cyc(); mid();
        chk("stall dec c3", 32'(decode_en_blk), 32'd0);
        chk("stall vld c3", 32'(rd_vld), 32'd1);
        chk("stall rd_addr c3", 32'(rd_addr), 32'd9);
        chk("stall ack c3", 32'(req_ack), 32'd0);
        cyc(); mid();
        chk("stall dec c4", 32'(decode_en_blk), 32'd0);
        chk("stall busy c4", 32'(busy), 32'd0);
        cyc(); mid();
        chk("stall dec c5", 32'(decode_en_blk), 32'd0);
        chk("stall ack c5", 32'(req_ack), 32'd0);
        cyc(); stall_in = 1'b0; mid();
        chk("stall ack c6", 32'(req_ack), 32'h0004);
        cyc(); mid();
        chk("stall dec c7", 32'(decode_en_blk), 32'd1);
        chk("stall addr c7", 32'(addr_seg), 32'd2);
        $display("stall: issue after release addr_seg=%0d", addr_seg);
        cyc(); cyc(); mid();
        chk("stall vld c9", 32'(rd_vld), 32'd1);
        chk("stall rd_addr c9", 32'(rd_addr), 32'd2);

        // Repeat request on leaf 4 in the cycle it is granted
        do_reset();
        leaf_req = 16'h0011; mid();
        chk("coll ack c0", 32'(req_ack), 32'h0001);
        cyc(); leaf_req = '0; mid();
        chk("coll addr c1", 32'(addr_seg), 32'd0);
        cyc();
        cyc(); leaf_req = 16'h0010; mid();
        chk("coll ack c3", 32'(req_ack), 32'h0010);
        cyc(); leaf_req = '0; mid();
        chk("coll dec c4", 32'(decode_en_blk), 32'd1);
        chk("coll addr c4", 32'(addr_seg), 32'd4);
        cyc(); cyc(); mid();
        chk("coll ack c6", 32'(req_ack), 32'h0010);
        cyc(); mid();
        chk("coll dec c7", 32'(decode_en_blk), 32'd1);
        chk("coll addr c7", 32'(addr_seg), 32'd4);
        $display("coll: second issue addr_seg=%0d", addr_seg);
        cyc(); cyc(); mid();
        chk("coll vld c9", 32'(rd_vld), 32'd1);
        chk("coll ack c9", 32'(req_ack), 32'd0);
        cyc(); mid();
        chk("coll busy c10", 32'(busy), 32'd0);
        cyc(); mid();
        chk("coll dec c11", 32'(decode_en_blk), 32'd0);

        // Reset during WAIT after issuing leaf 5, with leaf 8 still pending
        do_reset();
        leaf_req = 16'h0120; mid();
        chk("rstw ack c0", 32'(req_ack), 32'h0020);
        cyc(); leaf_req = '0; mid();
        chk("rstw addr c1", 32'(addr_seg), 32'd5);
        cyc(); rst_b = 1'b0; #1;
        chk("rstw dec", 32'(decode_en_blk), 32'd0);
        chk("rstw addr", 32'(addr_seg), 32'd0);
        chk("rstw busy", 32'(busy), 32'd0);
        chk("rstw vld", 32'(rd_vld), 32'd0);
        chk("rstw rd_addr", 32'(rd_addr), 32'd0);
        chk("rstw ack", 32'(req_ack), 32'd0);
        cyc(); rst_b = 1'b1;
        for (int c = 0; c < 6; c++) begin
            mid();
            chk($sformatf("rstw post vld %0d", c), 32'(rd_vld), 32'd0);
            chk($sformatf("rstw post dec %0d", c), 32'(decode_en_blk), 32'd0);
            chk($sformatf("rstw post ack %0d", c), 32'(req_ack), 32'd0);
            chk($sformatf("rstw post busy %0d", c), 32'(busy), 32'd0);
            cyc();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
